// File: rtl/gpr_pkg.sv
// Shared sizing helpers and the byte-merge primitive for the multiport GPR.
package gpr_pkg;

   function automatic int bytes_of(input int data_width);
      return data_width / 8;
   endfunction

   function automatic int pend_max(input int pend_w);
      return (2 ** pend_w) - 1;
   endfunction

   // byte_n is active-low: 0 takes the new byte, 1 keeps the old one
   function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                             input logic [7:0] new_b,
                                             input logic       byte_n);
      return byte_n ? old_b : new_b;
   endfunction

endpackage

// File: rtl/gpr_pend_cnt.sv
// Saturating pending-write counter for one register, with a sticky underflow flag.
module gpr_pend_cnt
   import gpr_pkg::*;
#(
   parameter int PEND_W = 2,
   parameter int CW     = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [CW-1:0] inc,
   input  logic [CW-1:0] dec,
   output logic          busy,
   output logic          full,
   output logic          err
);
   localparam int PMAX = pend_max(PEND_W);

   logic [PEND_W-1:0] cnt;
   logic [PEND_W-1:0] cnt_nxt;
   logic              under;
   int                sum;

   // Net change is applied once, then clamped at both ends
   always_comb begin
      sum     = int'(cnt) + int'(inc) - int'(dec);
      under   = 1'b0;
      cnt_nxt = PEND_W'(sum);
      if (sum < 0) begin
         under   = 1'b1;
         cnt_nxt = '0;
      end else if (sum > PMAX) begin
         cnt_nxt = PEND_W'(PMAX);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
         err <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         if (under) err <= 1'b1;
      end
   end

   assign busy = (cnt != '0);
   assign full = (cnt == PEND_W'(PMAX));

endmodule

// File: rtl/gpr_multiport.sv
// Multiport register file: byte-enabled writes with port-priority merge,
// write-first bypassed reads, and a per-register pending-write scoreboard.
module gpr_multiport
   import gpr_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_RD     = 4,
   parameter int NUM_WR     = 2,
   parameter int PEND_W     = 2
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NUM_RD*ADDR_WIDTH-1:0]        rd_addr,
   output logic [NUM_RD*DATA_WIDTH-1:0]        rd_data,
   output logic [NUM_RD-1:0]                   rd_pending,
   input  logic [NUM_WR-1:0]                   wr_en,
   input  logic [NUM_WR*ADDR_WIDTH-1:0]        wr_addr,
   input  logic [NUM_WR*DATA_WIDTH-1:0]        wr_data,
   input  logic [NUM_WR*(DATA_WIDTH/8)-1:0]    wr_byte_n,
   input  logic [NUM_WR-1:0]                   iss_en,
   input  logic [NUM_WR*ADDR_WIDTH-1:0]        iss_addr,
   output logic [NUM_WR-1:0]                   iss_full,
   output logic                                sb_err
);
   localparam int AW   = ADDR_WIDTH;
   localparam int DW   = DATA_WIDTH;
   localparam int NB   = bytes_of(DATA_WIDTH);
   localparam int NREG = 2 ** ADDR_WIDTH;
   localparam int CW   = $clog2(NUM_WR + 1);

   logic [DW-1:0]   regs [NREG];
   logic [DW-1:0]   nxt  [NREG];
   logic [NREG-1:0] busy;
   logic [NREG-1:0] full;
   logic [NREG-1:0] err;

   // Next value of every register; higher ports apply last so they win per byte.
   // Reads use the same array, which gives write-first bypass for free.
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         nxt[r] = regs[r];
         for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en[k] && (wr_addr[k*AW +: AW] == AW'(r))) begin
               for (int b = 0; b < NB; b++) begin
                  nxt[r][b*8 +: 8] = byte_merge(nxt[r][b*8 +: 8],
                                                wr_data[k*DW + b*8 +: 8],
                                                wr_byte_n[k*NB + b]);
               end
            end
         end
      end
      nxt[0] = '0;
   end

   always_ff @(posedge clk) begin
      for (int r = 0; r < NREG; r++) begin
         regs[r] <= reset ? '0 : nxt[r];
      end
   end

   assign busy[0] = 1'b0;
   assign full[0] = 1'b0;
   assign err[0]  = 1'b0;

   for (genvar r = 1; r < NREG; r++) begin : g_pend
      logic [CW-1:0] inc;
      logic [CW-1:0] dec;

      always_comb begin
         inc = '0;
         dec = '0;
         for (int k = 0; k < NUM_WR; k++) begin
            if (iss_en[k] && (iss_addr[k*AW +: AW] == AW'(r))) inc = inc + CW'(1);
            if (wr_en[k]  && (wr_addr[k*AW +: AW]  == AW'(r))) dec = dec + CW'(1);
         end
      end

      gpr_pend_cnt #(.PEND_W(PEND_W), .CW(CW)) u_cnt (
         .clk   (clk),
         .reset (reset),
         .inc   (inc),
         .dec   (dec),
         .busy  (busy[r]),
         .full  (full[r]),
         .err   (err[r])
      );
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      assign rd_data[i*DW +: DW] = nxt[rd_addr[i*AW +: AW]];
      assign rd_pending[i]       = busy[rd_addr[i*AW +: AW]];
   end

   for (genvar k = 0; k < NUM_WR; k++) begin : g_iss
      assign iss_full[k] = full[iss_addr[k*AW +: AW]];
   end

   assign sb_err = |err;

endmodule

// File: tb/tb_gpr_multiport.sv
// Directed table plus randomized checking of gpr_multiport against a behavioural model.
module tb_gpr_multiport;
   localparam int AW = 5;
   localparam int DW = 32;
   localparam int NR = 4;
   localparam int NW = 2;
   localparam int NB = 4;
   localparam int PMAX = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic [NR*AW-1:0]  rd_addr;
   logic [NR*DW-1:0]  rd_data;
   logic [NR-1:0]     rd_pending;
   logic [NW-1:0]     wr_en;
   logic [NW*AW-1:0]  wr_addr;
   logic [NW*DW-1:0]  wr_data;
   logic [NW*NB-1:0]  wr_byte_n;
   logic [NW-1:0]     iss_en;
   logic [NW*AW-1:0]  iss_addr;
   logic [NW-1:0]     iss_full;
   logic              sb_err;

   int nvec = 0;
   int nerr = 0;

   logic [31:0] m_mem [32];
   int          m_cnt [32];
   bit          m_err;

   gpr_multiport #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW), .PEND_W(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_pending (rd_pending),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_byte_n  (wr_byte_n),
      .iss_en     (iss_en),
      .iss_addr   (iss_addr),
      .iss_full   (iss_full),
      .sb_err     (sb_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] rdv(input int i);
      return rd_data[i*DW +: DW];
   endfunction

   // Reference read: stored word with this cycle's enabled bytes forwarded, port order = priority
   function automatic logic [31:0] m_read(input int a);
      logic [31:0] v;
      if (a == 0) return 32'h0;
      v = m_mem[a];
      for (int k = 0; k < NW; k++)
         if (wr_en[k] && int'(wr_addr[k*AW +: AW]) == a)
            for (int b = 0; b < NB; b++)
               if (!wr_byte_n[k*NB + b]) v[b*8 +: 8] = wr_data[k*DW + b*8 +: 8];
      return v;
   endfunction

   task automatic m_commit();
      logic [31:0] nv [32];
      int n;
      if (reset) begin
         for (int a = 0; a < 32; a++) begin m_mem[a] = '0; m_cnt[a] = 0; end
         m_err = 1'b0;
         return;
      end
      for (int a = 1; a < 32; a++) nv[a] = m_read(a);
      for (int a = 1; a < 32; a++) begin
         m_mem[a] = nv[a];
         n = m_cnt[a];
         for (int k = 0; k < NW; k++) begin
            if (iss_en[k] && int'(iss_addr[k*AW +: AW]) == a) n++;
            if (wr_en[k]  && int'(wr_addr[k*AW +: AW])  == a) n--;
         end
         if (n < 0) begin n = 0; m_err = 1'b1; end
         if (n > PMAX) n = PMAX;
         m_cnt[a] = n;
      end
   endtask

   task automatic tick();
      m_commit();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en = '0; wr_addr = '0; wr_data = '0; wr_byte_n = '1;
      iss_en = '0; iss_addr = '0;
   endtask

   task automatic set_wr(input int k, input logic [4:0] a, input logic [31:0] d, input logic [3:0] bn);
      wr_en[k] = 1'b1;
      wr_addr[k*AW +: AW] = a;
      wr_data[k*DW +: DW] = d;
      wr_byte_n[k*NB +: NB] = bn;
   endtask

   task automatic set_iss(input int k, input logic [4:0] a, input logic en);
      iss_en[k] = en;
      iss_addr[k*AW +: AW] = a;
   endtask

   task automatic set_rd(input int i, input logic [4:0] a);
      rd_addr[i*AW +: AW] = a;
   endtask

   typedef struct {
      bit [1:0]  we;
      bit [4:0]  wa0, wa1;
      bit [31:0] wd0, wd1;
      bit [3:0]  bn0, bn1;
      bit [4:0]  ra;
      bit [31:0] exp_byp, exp_st;
   } vec_t;

   vec_t tbl [9];

   initial begin
      tbl[0] = '{2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        4'h0, 4'hF, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
      tbl[1] = '{2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0,        4'h0, 4'hF, 5'd0, 32'h0,        32'h0};
      tbl[2] = '{2'b01, 5'd5, 5'd0, 32'h11223344, 32'h0,        4'hA, 4'hF, 5'd5, 32'hDE22BE44, 32'hDE22BE44};
      tbl[3] = '{2'b11, 5'd7, 5'd7, 32'hAAAAAAAA, 32'h55555555, 4'h0, 4'hC, 5'd7, 32'hAAAA5555, 32'hAAAA5555};
      tbl[4] = '{2'b11, 5'd8, 5'd9, 32'h01020304, 32'hA5A5A5A5, 4'h0, 4'h6, 5'd9, 32'hA50000A5, 32'hA50000A5};
      tbl[5] = '{2'b11, 5'd8, 5'd8, 32'h33333333, 32'h44444444, 4'h0, 4'h3, 5'd8, 32'h44443333, 32'h44443333};
      tbl[6] = '{2'b10, 5'd0, 5'd7, 32'h0,        32'hFFFFFFFF, 4'hF, 4'hF, 5'd7, 32'hAAAA5555, 32'hAAAA5555};
      tbl[7] = '{2'b01, 5'd8, 5'd0, 32'h000000EE, 32'h0,        4'hE, 4'hF, 5'd8, 32'h444433EE, 32'h444433EE};
      tbl[8] = '{2'b11, 5'd0, 5'd0, 32'h12345678, 32'h9ABCDEF0, 4'h0, 4'h0, 5'd0, 32'h0,        32'h0};

      idle();
      rd_addr = '0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      for (int i = 0; i < NR; i++) set_rd(i, 5'(i + 4));
      set_iss(0, 5'd4, 1'b0);
      set_iss(1, 5'd5, 1'b0);
      #2;
      for (int i = 0; i < NR; i++) begin
         chk("reset_rd_data", rdv(i), 32'h0);
         chk("reset_rd_pending", 32'(rd_pending[i]), 32'h0);
      end
      chk("reset_iss_full", 32'(iss_full), 32'h0);
      chk("reset_sb_err", 32'(sb_err), 32'h0);

      // Table: bypass value in the write cycle, stored value the cycle after
      foreach (tbl[n]) begin
         idle();
         if (tbl[n].we[0]) set_wr(0, tbl[n].wa0, tbl[n].wd0, tbl[n].bn0);
         if (tbl[n].we[1]) set_wr(1, tbl[n].wa1, tbl[n].wd1, tbl[n].bn1);
         set_rd(0, tbl[n].ra);
         #2;
         chk($sformatf("tbl%0d_bypass", n), rdv(0), tbl[n].exp_byp);
         tick();
         idle();
         set_rd(2, tbl[n].ra);
         #2;
         chk($sformatf("tbl%0d_stored", n), rdv(2), tbl[n].exp_st);
      end
      chk("tbl_unissued_wb_err", 32'(sb_err), 32'h1);

      reset = 1'b1;
      tick();
      reset = 1'b0;
      set_rd(0, 5'd5);
      #2;
      chk("reset_clears_err", 32'(sb_err), 32'h0);
      chk("reset_clears_r5", rdv(0), 32'h0);

      // Scoreboard saturation and drain on r3
      idle();
      set_rd(1, 5'd3);
      set_iss(0, 5'd3, 1'b1);
      set_iss(1, 5'd3, 1'b0);
      #2;
      chk("iss_full_cnt0", 32'(iss_full[0]), 32'h0);
      tick();
      #2;
      chk("pend_cnt1", 32'(rd_pending[1]), 32'h1);
      chk("iss_full_cnt1", 32'(iss_full[0]), 32'h0);
      tick();
      #2;
      chk("iss_full_cnt2", 32'(iss_full[1]), 32'h0);
      tick();
      #2;
      chk("iss_full_cnt3", 32'(iss_full), 32'h3);
      tick();
      set_iss(0, 5'd3, 1'b0);
      #2;
      chk("iss_full_after_drop", 32'(iss_full[0]), 32'h1);
      set_wr(0, 5'd3, 32'hCAFEF00D, 4'hF);
      #2;
      chk("pend_held_during_wb", 32'(rd_pending[1]), 32'h1);
      tick();
      idle();
      set_iss(0, 5'd3, 1'b0);
      #2;
      chk("iss_full_cnt2_drain", 32'(iss_full[0]), 32'h0);
      chk("pend_cnt2_drain", 32'(rd_pending[1]), 32'h1);
      set_wr(0, 5'd3, 32'h77777777, 4'h0);
      #2;
      chk("wb_bypass_r3", rdv(1), 32'h77777777);
      tick();
      idle();
      set_wr(1, 5'd3, 32'h0, 4'hF);
      tick();
      idle();
      #2;
      chk("pend_cnt0_drain", 32'(rd_pending[1]), 32'h0);
      chk("no_err_after_drain", 32'(sb_err), 32'h0);
      chk("r3_stored", rdv(1), 32'h77777777);

      // Issue and writeback together at count zero: no change, no error
      set_iss(0, 5'd10, 1'b1);
      set_wr(1, 5'd10, 32'h0000ABCD, 4'h0);
      set_rd(3, 5'd10);
      tick();
      idle();
      #2;
      chk("iss_wb_same_pend", 32'(rd_pending[3]), 32'h0);
      chk("iss_wb_same_err", 32'(sb_err), 32'h0);

      // Register 0 never pends
      set_iss(0, 5'd0, 1'b1);
      set_iss(1, 5'd0, 1'b1);
      set_rd(0, 5'd0);
      tick();
      tick();
      tick();
      #2;
      chk("r0_pending", 32'(rd_pending[0]), 32'h0);
      chk("r0_iss_full", 32'(iss_full), 32'h0);
      idle();

      // Unmatched writeback sets a sticky error
      set_wr(0, 5'd9, 32'h1, 4'h0);
      tick();
      idle();
      tick();
      tick();
      #2;
      chk("err_sticky", 32'(sb_err), 32'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #2;
      chk("err_cleared", 32'(sb_err), 32'h0);

      // Reset overrides a same-cycle write and issue
      set_wr(0, 5'd4, 32'hFFFFFFFF, 4'h0);
      set_iss(0, 5'd4, 1'b1);
      tick();
      idle();
      reset = 1'b1;
      set_wr(0, 5'd4, 32'h00001234, 4'h0);
      set_iss(1, 5'd4, 1'b1);
      tick();
      reset = 1'b0;
      idle();
      set_rd(0, 5'd4);
      #2;
      chk("reset_vs_write_r4", rdv(0), 32'h0);
      chk("reset_vs_issue_r4", 32'(rd_pending[0]), 32'h0);

      // Randomized phase against the model
      for (int c = 0; c < 1500; c++) begin
         reset = ($urandom_range(0, 63) == 0);
         for (int k = 0; k < NW; k++) begin
            wr_en[k] = ($urandom_range(0, 2) == 0);
            wr_addr[k*AW +: AW] = 5'($urandom_range(0, 7));
            wr_data[k*DW +: DW] = $urandom;
            wr_byte_n[k*NB +: NB] = 4'($urandom_range(0, 15));
            iss_en[k] = ($urandom_range(0, 1) == 0);
            iss_addr[k*AW +: AW] = 5'($urandom_range(0, 7));
         end
         for (int i = 0; i < NR; i++)
            set_rd(i, ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)));
         #2;
         for (int i = 0; i < NR; i++) begin
            int a;
            a = int'(rd_addr[i*AW +: AW]);
            chk($sformatf("rnd_rd_data%0d", i), rdv(i), m_read(a));
            chk($sformatf("rnd_rd_pending%0d", i), 32'(rd_pending[i]), 32'(a != 0 && m_cnt[a] != 0));
         end
         for (int k = 0; k < NW; k++) begin
            int a;
            a = int'(iss_addr[k*AW +: AW]);
            chk($sformatf("rnd_iss_full%0d", k), 32'(iss_full[k]), 32'(a != 0 && m_cnt[a] == PMAX));
         end
         chk("rnd_sb_err", 32'(sb_err), 32'(m_err));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
